// File: rtl/multi_debouncer_pkg.sv
// ============================================================================
// Module   : multi_debouncer_pkg
// Purpose  : Default timing constants and a sizing helper for multi_debouncer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multi_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_100MHZ = 65535;
    localparam int HOLD_1S_100MHZ         = 100000000;
    localparam int REPEAT_200MS_100MHZ    = 20000000;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input longint value);
        int     r;
        longint v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 63; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_debouncer_channel.sv
// ============================================================================
// Module   : debounce_channel
// Purpose  : One input: 2-flop synchroniser, debounce timer, press/release,
//            long-press and auto-repeat pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int HOLD_W          = 27,
    parameter int HOLD_CYCLES     = HOLD_1S_100MHZ,
    parameter int REPEAT_CYCLES   = REPEAT_200MS_100MHZ,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_switch,
    output logic o_state,
    output logic o_trans_up,
    output logic o_trans_dn,
    output logic o_long_press,
    output logic o_repeat_pulse
);

    localparam logic [CNT_W-1:0]  c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_rep_last  = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic              c_rep_en    = (REPEAT_EN != 0);

    logic              r_sync0;
    logic              r_sync1;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_state;
    logic              r_up;
    logic              r_dn;
    logic [HOLD_W-1:0] r_hold;
    logic              r_flag;
    logic              r_long;
    logic              r_rep;

    logic w_mismatch;
    logic w_toggle;
    logic w_release;

    assign w_mismatch = r_sync1 ^ r_state;
    assign w_toggle   = w_mismatch && (r_cnt == c_deb_last);
    assign w_release  = w_toggle && r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_cnt   <= '0;
            r_state <= 1'b0;
            r_up    <= 1'b0;
            r_dn    <= 1'b0;
        end else begin
            r_sync0 <= i_switch;
            r_sync1 <= r_sync0;
            r_up    <= 1'b0;
            r_dn    <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
                r_up    <= ~r_state;
                r_dn    <= r_state;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A release landing on a terminal count suppresses that pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_flag <= 1'b0;
            r_long <= 1'b0;
            r_rep  <= 1'b0;
        end else begin
            r_long <= 1'b0;
            r_rep  <= 1'b0;
            if (!r_state || w_release) begin
                r_hold <= '0;
                r_flag <= 1'b0;
            end else if (!r_flag) begin
                if (r_hold == c_hold_last) begin
                    r_long <= 1'b1;
                    r_flag <= 1'b1;
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end else if (c_rep_en) begin
                if (r_hold == c_rep_last) begin
                    r_rep  <= 1'b1;
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + 1'b1;
                end
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign o_state        = r_state;
    assign o_trans_up     = r_up;
    assign o_trans_dn     = r_dn;
    assign o_long_press   = r_long;
    assign o_repeat_pulse = r_rep;

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module   : multi_debouncer
// Purpose  : N independent debounced channels with press/release, long-press
//            and auto-repeat pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int HOLD_W          = 27,
    parameter int HOLD_CYCLES     = HOLD_1S_100MHZ,
    parameter int REPEAT_CYCLES   = REPEAT_200MS_100MHZ,
    parameter int REPEAT_EN       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] switch_input,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] trans_up,
    output logic [CHANNELS-1:0] trans_dn,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam longint c_cnt_max  = (longint'(1) << CNT_W) - 1;
    localparam longint c_hold_max = (longint'(1) << HOLD_W) - 1;

    if ((DEBOUNCE_CYCLES < 2) || (longint'(DEBOUNCE_CYCLES) > c_cnt_max)) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if ((HOLD_CYCLES < 2) || (longint'(HOLD_CYCLES) > c_hold_max)) begin : g_bad_hold
        $error("HOLD_CYCLES out of range for HOLD_W");
    end
    if ((REPEAT_CYCLES < 2) || (longint'(REPEAT_CYCLES) > c_hold_max)) begin : g_bad_repeat
        $error("REPEAT_CYCLES out of range for HOLD_W");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_W          (HOLD_W),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_EN)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .i_switch       (switch_input[i]),
            .o_state        (state[i]),
            .o_trans_up     (trans_up[i]),
            .o_trans_dn     (trans_dn[i]),
            .o_long_press   (long_press[i]),
            .o_repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

`default_nettype wire
